// File: rtl/mm_job_sched.sv
// Job sequencer for the mm systolic core: frames host A/B beats into the core,
// drains C back to the host, and generates TLAST from beat counts.
module mm_job_sched #(
    parameter int M       = 8,
    parameter int N1      = 8,
    parameter int N2      = 8,
    parameter int D_W     = 8,
    parameter int D_W_ACC = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              err_clr,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic              s_tlast,
    output logic [DATA_W-1:0] c_s_tdata,
    output logic              c_s_tvalid,
    input  logic              c_s_tready,
    output logic              c_s_tlast,
    input  logic [DATA_W-1:0] c_m_tdata,
    input  logic              c_m_tvalid,
    output logic              c_m_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic              busy,
    output logic              err_tlast,
    output logic              err_timeout,
    output logic [CNT_W-1:0]  jobs_done
);

    localparam int BA     = M * N1 * D_W / DATA_W;
    localparam int BB     = N1 * N2 * D_W / DATA_W;
    localparam int BC     = M * N2 * D_W_ACC / DATA_W;
    localparam int BMAX   = (BA > BB) ? ((BA > BC) ? BA : BC) : ((BB > BC) ? BB : BC);
    localparam int BEAT_W = $clog2(BMAX + 1);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    // Matrix geometry must pack into a whole number of stream beats.
    if ((M * N1 * D_W) % DATA_W != 0 || (N1 * N2 * D_W) % DATA_W != 0 ||
        (M * N2 * D_W_ACC) % DATA_W != 0) begin : g_bad_geometry
        $error("mm_job_sched: matrix sizes are not a whole number of DATA_W beats");
    end

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD_A = 2'd1;
    localparam logic [1:0] LOAD_B = 2'd2;
    localparam logic [1:0] DRAIN  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              err_tlast_q, err_tlast_d;
    logic              err_timeout_q, err_timeout_d;
    logic [CNT_W-1:0]  jobs_q, jobs_d;
    logic              tlast_set, timeout_set;
    logic              b_final;

    assign c_s_tdata   = s_tdata;
    assign m_tdata     = c_m_tdata;
    assign busy        = (state_q != IDLE);
    assign err_tlast   = err_tlast_q;
    assign err_timeout = err_timeout_q;
    assign jobs_done   = jobs_q;
    assign b_final     = (state_q == LOAD_B) && (beat_q == BEAT_W'(BB - 1));

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path infers a latch.
        state_d     = state_q;
        beat_d      = beat_q;
        idle_d      = '0;
        jobs_d      = jobs_q;
        tlast_set   = 1'b0;
        timeout_set = 1'b0;
        s_tready    = 1'b0;
        c_s_tvalid  = 1'b0;
        c_s_tlast   = 1'b0;
        c_m_tready  = 1'b0;
        m_tvalid    = 1'b0;
        m_tlast     = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) state_d = LOAD_A;
            end
            LOAD_A, LOAD_B: begin
                s_tready   = c_s_tready;
                c_s_tvalid = s_tvalid;
                c_s_tlast  = b_final;
                if (s_tvalid && c_s_tready) begin
                    // Host TLAST is only audited; sequencing follows the beat counts.
                    tlast_set = (s_tlast != b_final);
                    if (state_q == LOAD_A && beat_q == BEAT_W'(BA - 1)) begin
                        state_d = LOAD_B;
                        beat_d  = '0;
                    end else if (b_final) begin
                        state_d = DRAIN;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                m_tvalid   = c_m_tvalid;
                c_m_tready = m_tready;
                m_tlast    = (beat_q == BEAT_W'(BC - 1));
                if (c_m_tvalid) begin
                    if (m_tready) begin
                        if (beat_q == BEAT_W'(BC - 1)) begin
                            jobs_d  = jobs_q + 1'b1;
                            state_d = IDLE;
                            beat_d  = '0;
                        end else begin
                            beat_d = beat_q + 1'b1;
                        end
                    end
                end else if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
                    timeout_set = 1'b1;
                    state_d     = IDLE;
                    beat_d      = '0;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        err_tlast_d   = tlast_set   | (err_tlast_q   & ~err_clr);
        err_timeout_d = timeout_set | (err_timeout_q & ~err_clr);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            beat_q        <= '0;
            idle_q        <= '0;
            err_tlast_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            jobs_q        <= '0;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            idle_q        <= idle_d;
            err_tlast_q   <= err_tlast_d;
            err_timeout_q <= err_timeout_d;
            jobs_q        <= jobs_d;
        end
    end

endmodule
